// File: rtl/agc_gain_apply.sv
// Applies the committed AGC gain to a signed sample stream with rounding and saturation.
// Gain updates from the estimator are held and committed only at frame boundaries.
module agc_gain_apply #(
    parameter int DIN_WIDTH  = 8,
    parameter int DIN_POINT  = 7,
    parameter int GAIN_WIDTH = 12,
    parameter int GAIN_POINT = 10,
    parameter int DOUT_WIDTH = 8,
    parameter int DOUT_POINT = 7,
    parameter int FRAME_LEN  = 32,
    parameter int GAIN_INIT  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DIN_WIDTH-1:0]  din,
    input  logic                         din_valid,
    input  logic [GAIN_WIDTH-1:0]        gain,
    input  logic                         gain_valid,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         sat,
    output logic [15:0]                  sat_count,
    output logic [GAIN_WIDTH-1:0]        gain_active,
    output logic                         gain_pending
);

    localparam int PW  = DIN_WIDTH + GAIN_WIDTH + 1;
    localparam int SW  = PW + 1;
    localparam int SH  = DIN_POINT + GAIN_POINT - DOUT_POINT;
    localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [FCW-1:0]       FRAME_LAST = FCW'(FRAME_LEN - 1);
    localparam logic signed [PW:0]   RND_BIAS   = SW'(2 ** (SH - 1));
    localparam logic signed [PW:0]   OUT_MAX    = SW'(2 ** (DOUT_WIDTH - 1) - 1);
    localparam logic signed [PW:0]   OUT_MIN    = SW'(-(2 ** (DOUT_WIDTH - 1)));

    // Reset asserts asynchronously but releases on a clock edge.
    logic rst_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 1'b0;
        else      rst_sync <= 1'b1;
    end

    logic [FCW-1:0]        frame_cnt;
    logic [GAIN_WIDTH-1:0] gain_pend;
    logic                  frame_end;

    assign frame_end = din_valid && (frame_cnt == FRAME_LAST);

    // A strobe arriving on the frame's last sample is committed directly.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            frame_cnt    <= '0;
            gain_pend    <= '0;
            gain_pending <= 1'b0;
            gain_active  <= GAIN_WIDTH'(GAIN_INIT);
        end else begin
            if (din_valid) frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
            if (frame_end && (gain_valid || gain_pending)) begin
                gain_active  <= gain_valid ? gain : gain_pend;
                gain_pending <= 1'b0;
            end else if (gain_valid) begin
                gain_pend    <= gain;
                gain_pending <= 1'b1;
            end
        end
    end

    // Valid-only stream: each stage advances when its valid is high, there is no ready/stall.
    logic                         v1, v2;
    logic signed [DIN_WIDTH-1:0]  d1;
    logic [GAIN_WIDTH-1:0]        g1;
    logic signed [PW-1:0]         p2;

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            d1 <= '0;
            g1 <= '0;
            p2 <= '0;
        end else begin
            v1 <= din_valid;
            v2 <= v1;
            if (din_valid) begin
                d1 <= din;
                g1 <= gain_active;
            end
            if (v1) p2 <= PW'(d1) * PW'($signed({1'b0, g1}));
        end
    end

    logic signed [PW:0]            rnd_sum;
    logic signed [PW:0]            shifted;
    logic signed [DOUT_WIDTH-1:0]  dout_n;
    logic                          sat_n;

    always_comb begin
        rnd_sum = $signed({p2[PW-1], p2}) + RND_BIAS;
        shifted = rnd_sum >>> SH;
        dout_n  = shifted[DOUT_WIDTH-1:0];
        sat_n   = 1'b0;
        if (shifted > OUT_MAX) begin
            dout_n = OUT_MAX[DOUT_WIDTH-1:0];
            sat_n  = 1'b1;
        end else if (shifted < OUT_MIN) begin
            dout_n = OUT_MIN[DOUT_WIDTH-1:0];
            sat_n  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sat        <= 1'b0;
            sat_count  <= '0;
        end else begin
            dout_valid <= v2;
            sat        <= v2 & sat_n;
            if (v2) dout <= dout_n;
            if (dout_valid && sat && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
        end
    end

endmodule
